// File: rtl/i2s_tdm_rx.sv
// rtl/i2s_tdm_rx.sv - I2S / left-justified / TDM serial-audio receiver for a master-mode ADC
//
// Purpose: oversamples bck/lrck/adata in the clk domain, locks to the frame structure and
// returns one SAMPLE_W-bit word per channel slot through a single-entry valid/ready register.
//
// Ports:
//   clk, rst                          system clock, synchronous active-low reset
//   bck, lrck, adata                  asynchronous serial inputs driven by the ADC
//   enable                            0 holds the receiver in WAIT_SYNC
//   fmt_sel                           0 = I2S (lrck fall, 1-bck data delay), 1 = LJ (lrck rise)
//   clr_ovr                           clears the sticky overrun flag
//   out_data, out_ch                  received word and its slot index
//   out_valid, out_ready              output handshake
//   locked                            receiver is in RUN
//   sync_err                          one-clk pulse on an early or missing frame edge
//   overrun                           sticky, a completed word was dropped

module i2s_tdm_rx #(
  parameter int SAMPLE_W    = 24,
  parameter int SLOT_W      = 32,
  parameter int NUM_CH      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bck,
  input  logic                      lrck,
  input  logic                      adata,
  input  logic                      enable,
  input  logic                      fmt_sel,
  input  logic                      clr_ovr,
  output logic [SAMPLE_W-1:0]       out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      locked,
  output logic                      sync_err,
  output logic                      overrun
);

  localparam int CW = $clog2(NUM_CH);
  localparam int BW = $clog2(SLOT_W);

  // fmt_sel is run-time selectable, so the I2S constraint (word ends before the slot does)
  // has to hold for every build.
  generate
    if (SAMPLE_W < 1 || SAMPLE_W >= SLOT_W || SLOT_W < 8 || SLOT_W > 64 ||
        NUM_CH < 2 || NUM_CH > 8 || LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_params
      $error("i2s_tdm_rx: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LOCKING   = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state_q;
  logic                bck_s1_q, bck_s2_q, bck_prev_q;
  logic                lrck_s1_q, lrck_s2_q, lrck_last_q;
  logic                adata_s1_q, adata_s2_q;
  logic                fmt_q;
  logic [BW-1:0]       bit_q;
  logic [CW-1:0]       slot_q;
  logic [3:0]          good_cnt_q;
  logic [SAMPLE_W-1:0] shift_q;
  logic [SAMPLE_W-1:0] out_data_q;
  logic [CW-1:0]       out_ch_q;
  logic                out_valid_q, locked_q, sync_err_q, overrun_q;

  logic                ev, fmt_eff, edge_seen, at_wrap;
  logic                good_edge, early, missing, enter_run, run_ev;
  logic                in_word, done, drop;
  logic [BW-1:0]       bit_d, first_bit, last_bit;
  logic [CW-1:0]       slot_d;
  logic [SAMPLE_W-1:0] word;

  always_comb begin
    ev        = bck_s2_q & ~bck_prev_q;
    // While hunting for sync the live fmt_sel picks the edge; afterwards the latched copy does.
    fmt_eff   = (state_q == WAIT_SYNC) ? fmt_sel : fmt_q;
    edge_seen = ev & (fmt_eff ? (lrck_s2_q & ~lrck_last_q) : (~lrck_s2_q & lrck_last_q));
    at_wrap   = (slot_q == CW'(NUM_CH - 1)) && (bit_q == BW'(SLOT_W - 1));
    good_edge = edge_seen & at_wrap;
    early     = edge_seen & ~at_wrap;
    missing   = ev & at_wrap & ~edge_seen;
    enter_run = (state_q == LOCKING) & good_edge & (good_cnt_q == 4'(LOCK_FRAMES - 1));
    // The frame whose edge completes locking is already captured.
    run_ev    = enable & ev & ~early & ~missing & ((state_q == RUN) | enter_run);

    // pos is kept as (slot, bit) so no multiply/divide by SLOT_W is needed.
    if (bit_q == BW'(SLOT_W - 1)) begin
      bit_d  = '0;
      slot_d = at_wrap ? '0 : slot_q + CW'(1);
    end else begin
      bit_d  = bit_q + BW'(1);
      slot_d = slot_q;
    end

    // I2S data sits one bck later inside the same slot; SAMPLE_W < SLOT_W keeps it in range.
    first_bit = fmt_q ? '0 : BW'(1);
    last_bit  = fmt_q ? BW'(SAMPLE_W - 1) : BW'(SAMPLE_W);
    in_word   = run_ev & (bit_d >= first_bit) & (bit_d <= last_bit);
    done      = run_ev & (bit_d == last_bit);
    word      = SAMPLE_W'({shift_q, adata_s2_q});
    drop      = done & out_valid_q & ~out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= WAIT_SYNC;
      bck_s1_q    <= 1'b0;
      bck_s2_q    <= 1'b0;
      bck_prev_q  <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_last_q <= 1'b0;
      adata_s1_q  <= 1'b0;
      adata_s2_q  <= 1'b0;
      fmt_q       <= 1'b0;
      bit_q       <= '0;
      slot_q      <= '0;
      good_cnt_q  <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bck_s1_q   <= bck;
      bck_s2_q   <= bck_s1_q;
      bck_prev_q <= bck_s2_q;
      lrck_s1_q  <= lrck;
      lrck_s2_q  <= lrck_s1_q;
      adata_s1_q <= adata;
      adata_s2_q <= adata_s1_q;
      if (ev) begin
        lrck_last_q <= lrck_s2_q;
      end

      sync_err_q <= 1'b0;
      if (!enable) begin
        state_q    <= WAIT_SYNC;
        locked_q   <= 1'b0;
        bit_q      <= '0;
        slot_q     <= '0;
        good_cnt_q <= '0;
      end else if (ev) begin
        unique case (state_q)
          WAIT_SYNC: begin
            if (edge_seen) begin
              state_q    <= LOCKING;
              fmt_q      <= fmt_sel;
              bit_q      <= '0;
              slot_q     <= '0;
              good_cnt_q <= '0;
            end
          end
          default: begin
            if (early) begin
              sync_err_q <= 1'b1;
              state_q    <= LOCKING;
              locked_q   <= 1'b0;
              bit_q      <= '0;
              slot_q     <= '0;
              good_cnt_q <= '0;
            end else if (missing) begin
              sync_err_q <= 1'b1;
              state_q    <= WAIT_SYNC;
              locked_q   <= 1'b0;
              bit_q      <= '0;
              slot_q     <= '0;
              good_cnt_q <= '0;
            end else begin
              bit_q  <= bit_d;
              slot_q <= slot_d;
              if ((state_q == LOCKING) && good_edge) begin
                good_cnt_q <= good_cnt_q + 4'd1;
                if (enter_run) begin
                  state_q  <= RUN;
                  locked_q <= 1'b1;
                end
              end
            end
          end
        endcase
      end

      if (in_word) begin
        shift_q <= word;
      end

      // Single-entry output register: a held word is never overwritten.
      if (done && !drop) begin
        out_data_q  <= word;
        out_ch_q    <= slot_d;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;
  assign overrun   = overrun_q;

endmodule
